// File: rtl/fpu_wb_regs.sv
// Wishbone register front-end for a floating-point unit.
// Holds operands A/B/C, the operation select and rounding mode, launches one
// FPU operation at a time and captures its result and exception flags.
// Optional feature macro: FPU_WB_IRQ_EN (completion interrupt with enable bit).
module fpu_wb_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [31:0] fpu_a_o,
   output logic [31:0] fpu_b_o,
   output logic [31:0] fpu_c_o,
   output logic [11:0] fpu_op_o,
   output logic [2:0]  fpu_rm_o,
   output logic        fpu_valid_o,
   input  logic [31:0] fpu_result_i,
   input  logic [4:0]  fpu_flags_i,
   input  logic        fpu_ready_i,
   output logic        irq_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [7:0] OFF_A      = 8'h00;
   localparam logic [7:0] OFF_B      = 8'h04;
   localparam logic [7:0] OFF_C      = 8'h08;
   localparam logic [7:0] OFF_RESULT = 8'h0C;
   localparam logic [7:0] OFF_FLAGS  = 8'h10;
   localparam logic [7:0] OFF_STATUS = 8'h14;
   localparam logic [7:0] OFF_OP     = 8'h1C;
   localparam logic [7:0] OFF_RM     = 8'h24;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t          r_state, w_state_next;
   logic            r_ack;
   logic [31:0]     r_dat_o;
   logic [31:0]     r_a, r_b, r_c, r_result;
   logic [4:0]      r_flags;
   logic [11:0]     r_op;
   logic [2:0]      r_rm;
   logic            r_done, r_timeout, r_launch;
   logic [CW-1:0]   r_cnt;

   logic            w_req, w_wr, w_wr_cfg, w_wr_status, w_busy;
   logic            w_ready, w_expire, w_ie;
   logic [7:0]      w_off;
   logic [31:0]     w_bmask, w_rdata, w_op_merged;

   // A held request is acked only every other cycle because r_ack masks it.
   assign w_req       = wbs_cyc_i & wbs_stb_i & ~r_ack &
                        (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign w_off       = wbs_adr_i[7:0];
   assign w_wr        = w_req & wbs_we_i;
   assign w_busy      = (r_state == ST_BUSY);
   // Operand/config writes are dropped while an operation is in flight.
   assign w_wr_cfg    = w_wr & ~w_busy;
   assign w_wr_status = w_wr & (w_off == OFF_STATUS) & wbs_sel_i[0];
   assign w_ready     = w_busy & fpu_ready_i;
   // Ready wins over a coinciding expiry.
   assign w_expire    = w_busy & ~fpu_ready_i & (r_cnt == CW'(TIMEOUT - 1));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bmask
         assign w_bmask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
      end
   endgenerate

   function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   assign w_op_merged = f_merge({20'b0, r_op}, wbs_dat_i, w_bmask);

   // Read data multiplexer; unmapped offsets read as zero.
   always_comb begin
      w_rdata = 32'b0;
      case (w_off)
         OFF_A:      w_rdata = r_a;
         OFF_B:      w_rdata = r_b;
         OFF_C:      w_rdata = r_c;
         OFF_RESULT: w_rdata = r_result;
         OFF_FLAGS:  w_rdata = {27'b0, r_flags};
         OFF_STATUS: w_rdata = {28'b0, w_ie, r_timeout, r_done, w_busy};
         OFF_OP:     w_rdata = {19'b0, fpu_valid_o, r_op};
         OFF_RM:     w_rdata = {29'b0, r_rm};
         default:    w_rdata = 32'b0;
      endcase
   end

   // Next-state logic for the launch / compute / complete sequence.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (r_launch) w_state_next = ST_BUSY;
         ST_BUSY: if (w_ready || w_expire) w_state_next = ST_DONE;
         ST_DONE: begin
            if (r_launch)     w_state_next = ST_BUSY;
            else if (!r_done) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register and BUSY cycle counter.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= (w_busy && w_state_next == ST_BUSY) ? r_cnt + 1'b1 : '0;
      end
   end

   // Bus handshake: single-cycle ack with registered read data.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack   <= 1'b0;
         r_dat_o <= 32'b0;
      end else begin
         r_ack   <= w_req;
         r_dat_o <= (w_req && !wbs_we_i) ? w_rdata : 32'b0;
      end
   end

   // Operand and configuration registers; launch is a one-cycle pulse into the FSM.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_a      <= 32'b0;
         r_b      <= 32'b0;
         r_c      <= 32'b0;
         r_op     <= 12'b0;
         r_rm     <= 3'b0;
         r_launch <= 1'b0;
      end else begin
         r_launch <= w_wr_cfg & (w_off == OFF_OP) & wbs_sel_i[1] & wbs_dat_i[12];
         if (w_wr_cfg) begin
            case (w_off)
               OFF_A:   r_a  <= f_merge(r_a, wbs_dat_i, w_bmask);
               OFF_B:   r_b  <= f_merge(r_b, wbs_dat_i, w_bmask);
               OFF_C:   r_c  <= f_merge(r_c, wbs_dat_i, w_bmask);
               OFF_OP:  r_op <= w_op_merged[11:0];
               OFF_RM:  if (wbs_sel_i[0]) r_rm <= wbs_dat_i[2:0];
               default: ;
            endcase
         end
      end
   end

   // Completion capture and W1C status bits.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_result  <= 32'b0;
         r_flags   <= 5'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_ready || w_expire) begin
         r_result  <= w_ready ? fpu_result_i : 32'b0;
         r_flags   <= w_ready ? fpu_flags_i : 5'b0;
         r_done    <= 1'b1;
         r_timeout <= w_expire;
      end else begin
         if (r_launch) r_done <= 1'b0;
         if (w_wr_status && wbs_dat_i[1]) r_done    <= 1'b0;
         if (w_wr_status && wbs_dat_i[2]) r_timeout <= 1'b0;
      end
   end

`ifdef FPU_WB_IRQ_EN
   logic r_ie, r_irq;

   // Interrupt enable and registered completion interrupt.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ie  <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (w_wr_status) r_ie <= wbs_dat_i[3];
         r_irq <= (r_done | r_timeout) & r_ie;
      end
   end

   assign w_ie  = r_ie;
   assign irq_o = r_irq;
`else
   assign w_ie  = 1'b0;
   assign irq_o = 1'b0;
`endif

   assign wbs_ack_o   = r_ack;
   assign wbs_dat_o   = r_dat_o;
   assign fpu_a_o     = r_a;
   assign fpu_b_o     = r_b;
   assign fpu_c_o     = r_c;
   assign fpu_op_o    = r_op;
   assign fpu_rm_o    = r_rm;
   assign fpu_valid_o = w_busy;

endmodule
